// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_lsu_pkg                                                      |
// | Shared opcodes, widths and FSM encoding for the MEM-stage LSU.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package mem_lsu_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;

  localparam logic                 ENABLE    = 1'b1;
  localparam logic                 DISABLE   = 1'b0;
  localparam logic [REG_BUS_W-1:0] ZERO_WORD = 32'h0000_0000;

  // Memory operation codes; every other aluop value is a non-memory op
  localparam logic [ALUOP_W-1:0] OP_LB  = 8'b1110_0000;
  localparam logic [ALUOP_W-1:0] OP_LH  = 8'b1110_0001;
  localparam logic [ALUOP_W-1:0] OP_LW  = 8'b1110_0011;
  localparam logic [ALUOP_W-1:0] OP_LBU = 8'b1110_0100;
  localparam logic [ALUOP_W-1:0] OP_LHU = 8'b1110_0101;
  localparam logic [ALUOP_W-1:0] OP_SB  = 8'b1110_1000;
  localparam logic [ALUOP_W-1:0] OP_SH  = 8'b1110_1001;
  localparam logic [ALUOP_W-1:0] OP_SW  = 8'b1110_1011;

  // Bus transaction state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

endpackage : mem_lsu_pkg
`default_nettype wire

// File: rtl/mem_lsu_align.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_align                                                        |
// | Big-endian lane select, store replication, load extract/extend   |
// | and misalignment detection. Purely combinational.                |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [ALUOP_W-1:0]   aluop,
  input  logic [1:0]           offset,
  input  logic [REG_BUS_W-1:0] store_data,
  input  logic [REG_BUS_W-1:0] load_word,
  output logic                 is_mem,
  output logic                 is_load,
  output logic                 is_store,
  output logic                 misalign,
  output logic [3:0]           sel,
  output logic [REG_BUS_W-1:0] store_lanes,
  output logic [REG_BUS_W-1:0] load_data
);

  logic       sz_b;
  logic       sz_h;
  logic       sz_w;
  logic       sext;
  logic [7:0] byte_val;
  logic [15:0] half_val;

  // Decode op, then derive lanes and data views from the byte offset
  always_comb begin
    is_mem   = DISABLE;
    is_load  = DISABLE;
    is_store = DISABLE;
    sext     = DISABLE;
    sz_b     = DISABLE;
    sz_h     = DISABLE;
    sz_w     = DISABLE;
    case (aluop)
      OP_LB:  begin is_load = ENABLE;  sz_b = ENABLE; sext = ENABLE; end
      OP_LBU: begin is_load = ENABLE;  sz_b = ENABLE; end
      OP_LH:  begin is_load = ENABLE;  sz_h = ENABLE; sext = ENABLE; end
      OP_LHU: begin is_load = ENABLE;  sz_h = ENABLE; end
      OP_LW:  begin is_load = ENABLE;  sz_w = ENABLE; end
      OP_SB:  begin is_store = ENABLE; sz_b = ENABLE; end
      OP_SH:  begin is_store = ENABLE; sz_h = ENABLE; end
      OP_SW:  begin is_store = ENABLE; sz_w = ENABLE; end
      default: ;
    endcase
    is_mem = is_load | is_store;

    // Byte 0 of the word sits in bits [31:24] (big-endian)
    case (offset)
      2'b00:   byte_val = load_word[31:24];
      2'b01:   byte_val = load_word[23:16];
      2'b10:   byte_val = load_word[15:8];
      default: byte_val = load_word[7:0];
    endcase
    half_val = offset[1] ? load_word[15:0] : load_word[31:16];

    misalign = (sz_h & offset[0]) | (sz_w & (offset != 2'b00));

    if (sz_b) begin
      sel         = 4'b1000 >> offset;
      store_lanes = {4{store_data[7:0]}};
      load_data   = {{24{sext & byte_val[7]}}, byte_val};
    end else if (sz_h) begin
      sel         = offset[1] ? 4'b0011 : 4'b1100;
      store_lanes = {2{store_data[15:0]}};
      load_data   = {{16{sext & half_val[15]}}, half_val};
    end else if (sz_w) begin
      sel         = 4'b1111;
      store_lanes = store_data;
      load_data   = load_word;
    end else begin
      sel         = 4'b0000;
      store_lanes = store_data;
      load_data   = load_word;
    end
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mem_lsu                                                          |
// | MEM-stage load/store unit: single-outstanding req/ack data bus   |
// | master with pipeline stall, flush drop and ack timeout.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rw_i,
  input  logic                  wreg_i,
  input  logic [REG_BUS_W-1:0]  wdata_i,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [REG_BUS_W-1:0]  mem_addr_i,
  input  logic [REG_BUS_W-1:0]  reg2_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] rw_o,
  output logic                  wreg_o,
  output logic [REG_BUS_W-1:0]  wdata_o,
  output logic                  stallreq_o,
  output logic                  excp_misalign_o,
  output logic                  excp_buserr_o,
  output logic                  dbus_req_o,
  output logic                  dbus_we_o,
  output logic [REG_BUS_W-1:0]  dbus_addr_o,
  output logic [3:0]            dbus_sel_o,
  output logic [REG_BUS_W-1:0]  dbus_wdata_o,
  input  logic [REG_BUS_W-1:0]  dbus_rdata_i,
  input  logic                  dbus_ack_i
);

  // Counter value on the last BUSY cycle allowed before abort
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(ACK_TIMEOUT - 1);

  lsu_state_t           state;
  logic [CNT_W-1:0]     cnt;
  logic                 drop;
  logic [REG_BUS_W-1:0] rdata_q;

  logic                 is_mem;
  logic                 is_load;
  logic                 is_store;
  logic                 misalign;
  logic [3:0]           sel;
  logic [REG_BUS_W-1:0] store_lanes;
  logic [REG_BUS_W-1:0] load_data;
  logic                 start;
  logic                 timeout_hit;

  // Extraction works on the captured word; the offset/op come from the
  // ex_mem inputs, which are held stable for the whole transaction.
  lsu_align u_align (
    .aluop       (aluop_i),
    .offset      (mem_addr_i[1:0]),
    .store_data  (reg2_i),
    .load_word   (rdata_q),
    .is_mem      (is_mem),
    .is_load     (is_load),
    .is_store    (is_store),
    .misalign    (misalign),
    .sel         (sel),
    .store_lanes (store_lanes),
    .load_data   (load_data)
  );

  assign start       = (state == ST_IDLE) && is_mem && !misalign && !flush_i;
  assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt == TO_LAST);

  // Bus FSM: launch, wait for ack or timeout, then one writeback cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      drop          <= DISABLE;
      rdata_q       <= ZERO_WORD;
      excp_buserr_o <= DISABLE;
      dbus_req_o    <= DISABLE;
      dbus_we_o     <= DISABLE;
      dbus_addr_o   <= ZERO_WORD;
      dbus_sel_o    <= 4'b0000;
      dbus_wdata_o  <= ZERO_WORD;
    end else begin
      excp_buserr_o <= DISABLE;
      case (state)
        ST_IDLE: begin
          if (start) begin
            dbus_req_o   <= ENABLE;
            dbus_we_o    <= is_store;
            dbus_addr_o  <= {mem_addr_i[31:2], 2'b00};
            dbus_sel_o   <= sel;
            dbus_wdata_o <= store_lanes;
            cnt          <= '0;
            drop         <= DISABLE;
            state        <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          cnt <= cnt + 1'b1;
          if (flush_i) begin
            drop <= ENABLE;
          end
          // Ack takes priority over a coinciding timeout
          if (dbus_ack_i) begin
            rdata_q    <= dbus_rdata_i;
            dbus_req_o <= DISABLE;
            drop       <= DISABLE;
            state      <= (drop || flush_i) ? ST_IDLE : ST_DONE;
          end else if (timeout_hit) begin
            dbus_req_o    <= DISABLE;
            excp_buserr_o <= ENABLE;
            drop          <= DISABLE;
            state         <= ST_IDLE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Writeback mux and stall request as a function of FSM state
  always_comb begin
    rw_o            = rw_i;
    wreg_o          = wreg_i;
    wdata_o         = wdata_i;
    stallreq_o      = DISABLE;
    excp_misalign_o = is_mem & misalign;
    case (state)
      ST_IDLE: begin
        if (flush_i) begin
          wreg_o = DISABLE;
        end else if (is_mem) begin
          wreg_o     = DISABLE;
          stallreq_o = ~misalign;
        end
      end
      ST_BUSY: begin
        wreg_o     = DISABLE;
        stallreq_o = ENABLE;
      end
      ST_DONE: begin
        wdata_o = load_data;
        wreg_o  = (is_load && !flush_i) ? wreg_i : DISABLE;
      end
      default: ;
    endcase
  end

endmodule : mem_lsu
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mem_lsu                                                       |
// | Randomized scoreboard bench for mem_lsu with a bus responder.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  localparam int T = 4;
  localparam logic [7:0] OP_ALU = 8'b0010_0101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rw_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [7:0]  aluop_i = OP_ALU;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] reg2_i = '0;
  logic        flush_i = 1'b0;
  logic [4:0]  rw_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o, excp_misalign_o, excp_buserr_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_rdata_i = '0;
  logic        dbus_ack_i = 1'b0;

  always #5 clk = ~clk;

  mem_lsu #(.ACK_TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rw_i(rw_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .aluop_i(aluop_i), .mem_addr_i(mem_addr_i), .reg2_i(reg2_i), .flush_i(flush_i),
    .rw_o(rw_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o),
    .excp_misalign_o(excp_misalign_o), .excp_buserr_o(excp_buserr_o),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_sel_o(dbus_sel_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_rdata_i(dbus_rdata_i), .dbus_ack_i(dbus_ack_i)
  );

  typedef struct {
    bit          timeout;
    logic [4:0]  rw;
    logic        wreg;
    logic [31:0] wdata;
    logic        misalign;
    int          stalls;
    int          reqc;
  } wb_t;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] wdata;
  } bus_t;

  wb_t  wb_q[$];
  bus_t bus_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   active = 1'b0;
  int   ack_wait = 1000;
  logic [31:0] resp_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model helpers: access size in bytes (0 = not memory)
  function automatic int op_size(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction
  function automatic bit op_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
  endfunction
  function automatic bit op_signed(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH);
  endfunction

  // Bus slave: ack after ack_wait cycles of request
  initial begin
    int  bcnt = 0;
    bit  acked = 0;
    forever begin
      @(negedge clk);
      if (dbus_req_o && !acked) begin
        if (bcnt == ack_wait) begin
          dbus_ack_i   = 1'b1;
          dbus_rdata_i = resp_rdata;
          acked        = 1'b1;
        end
        bcnt++;
      end else begin
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = $urandom;
        if (!dbus_req_o) begin
          bcnt  = 0;
          acked = 1'b0;
        end
      end
    end
  end

  // Monitor: bus requests and instruction retirement against queues
  initial begin
    int   stalls_seen = 0;
    int   req_cycles = 0;
    logic req_prev = 1'b0;
    bus_t b;
    wb_t  e;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_prev = 1'b0; stalls_seen = 0; req_cycles = 0;
      end else begin
        if (dbus_req_o && !req_prev) begin
          if (bus_q.size() == 0) begin
            errors++; checks++;
            $display("FAIL unexpected_req: got req=1 addr=%0h expected no request", dbus_addr_o);
          end else begin
            b = bus_q.pop_front();
            chk("bus_addr", dbus_addr_o, b.addr);
            chk("bus_sel", {28'd0, dbus_sel_o}, {28'd0, b.sel});
            chk("bus_we", {31'd0, dbus_we_o}, {31'd0, b.we});
            if (b.we) chk("bus_wdata", dbus_wdata_o, b.wdata);
          end
        end
        if (active) begin
          if (dbus_req_o) req_cycles++;
          if (excp_buserr_o || !stallreq_o) begin
            if (wb_q.size() == 0) begin
              errors++; checks++;
              $display("FAIL retire_empty: got retire expected none");
            end else begin
              e = wb_q.pop_front();
              chk("buserr", {31'd0, excp_buserr_o}, {31'd0, e.timeout});
              chk("stalls", stalls_seen, e.stalls);
              chk("req_cycles", req_cycles, e.reqc);
              chk("rw", {27'd0, rw_o}, {27'd0, e.rw});
              chk("wreg", {31'd0, wreg_o}, {31'd0, e.wreg});
              if (e.wreg) chk("wdata", wdata_o, e.wdata);
              if (!e.timeout) chk("misalign", {31'd0, excp_misalign_o}, {31'd0, e.misalign});
            end
            stalls_seen = 0;
            req_cycles  = 0;
          end else begin
            stalls_seen++;
          end
        end else if (excp_buserr_o) begin
          errors++; checks++;
          $display("FAIL stray_buserr: got 1 expected 0");
        end
        req_prev = dbus_req_o;
      end
    end
  end

  // fmode: 0 none, 1 flush at issue, 2 flush held from BUSY cycle fidx
  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                       input logic [31:0] rd, input int w, input int fmode, input int fidx,
                       input logic [4:0] rw, input logic wr, input logic [31:0] wd);
    int          sz, off, bidx;
    bit          mis, done;
    wb_t         e;
    bus_t        b;
    logic [31:0] m, v;
    sz  = op_size(op);
    off = int'(addr[1:0]);
    mis = (sz != 0) && ((off % sz) != 0);
    e.timeout = 0; e.rw = rw; e.wreg = 1'b0; e.wdata = '0;
    e.misalign = mis; e.stalls = 0; e.reqc = 0;
    if (sz == 0) begin
      e.wreg  = (fmode == 1) ? 1'b0 : wr;
      e.wdata = wd;
    end else if (!mis && fmode != 1) begin
      b.addr  = {addr[31:2], 2'b00};
      b.sel   = 4'(((1 << sz) - 1) << (4 - off - sz));
      b.we    = !op_load(op);
      b.wdata = (sz == 1) ? {4{r2[7:0]}} : (sz == 2) ? {2{r2[15:0]}} : r2;
      bus_q.push_back(b);
      if (w >= T) begin
        e.timeout = 1; e.stalls = T + 1; e.reqc = T;
      end else begin
        e.stalls = 2 + w; e.reqc = w + 1;
        if (op_load(op) && fmode != 2) begin
          m = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 1);
          v = (rd >> (8 * (4 - off - sz))) & m;
          if (op_signed(op) && v[8 * sz - 1]) v = v | ~m;
          e.wreg = wr; e.wdata = v;
        end
      end
    end
    wb_q.push_back(e);
    ack_wait = w; resp_rdata = rd;
    aluop_i = op; mem_addr_i = addr; reg2_i = r2; rw_i = rw; wreg_i = wr;
    wdata_i = wd; flush_i = (fmode == 1); active = 1'b1;
    bidx = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk); #1;
      if (excp_buserr_o || !stallreq_o) begin
        if (excp_buserr_o) flush_i = 1'b1;
        done = 1;
      end else if (dbus_req_o) begin
        if (fmode == 2 && bidx == fidx) flush_i = 1'b1;
        bidx++;
      end
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL retire_bound: got no retire within 64 cycles expected retire");
    end
    @(posedge clk); #1;
    active = 1'b0; flush_i = 1'b0; aluop_i = OP_ALU; wreg_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    logic [7:0] ops [9];
    logic [7:0] op;
    int w, fm, fi;
    ops[0] = OP_LB; ops[1] = OP_LBU; ops[2] = OP_LH; ops[3] = OP_LHU; ops[4] = OP_LW;
    ops[5] = OP_SB; ops[6] = OP_SH;  ops[7] = OP_SW; ops[8] = OP_ALU;

    // Reset: bus outputs cleared, pass-through active in IDLE
    rst = 1'b1; rw_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hCAFE;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, dbus_req_o}, 32'd0);
    chk("rst_addr", dbus_addr_o, 32'd0);
    chk("rst_sel", {28'd0, dbus_sel_o}, 32'd0);
    chk("rst_wdata", dbus_wdata_o, 32'd0);
    chk("rst_buserr", {31'd0, excp_buserr_o}, 32'd0);
    chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rst_wreg_pass", {31'd0, wreg_o}, 32'd1);
    chk("rst_wdata_pass", wdata_o, 32'hCAFE);
    @(posedge clk); #1;
    rst = 1'b0; wreg_i = 1'b0;

    // Directed cases
    issue(OP_ALU, 32'h0,   32'h0,        32'h0,        0, 0, 0, 5'd3, 1'b1, 32'h1234);
    issue(OP_LB,  32'h101, 32'h0,        32'h11F23344, 0, 0, 0, 5'd4, 1'b1, 32'h0);
    issue(OP_LBU, 32'h101, 32'h0,        32'h11F23344, 0, 0, 0, 5'd5, 1'b1, 32'h0);
    issue(OP_SH,  32'h202, 32'hAAAABEEF, 32'h0,        3, 0, 0, 5'd6, 1'b1, 32'h0);
    issue(OP_LW,  32'h6,   32'h0,        32'h0,        0, 0, 0, 5'd7, 1'b1, 32'h0);
    issue(OP_LW,  32'h10,  32'h0,        32'h12345678, T, 0, 0, 5'd8, 1'b1, 32'h0);
    issue(OP_LW,  32'h20,  32'h0,        32'h87654321, 3, 2, 1, 5'd9, 1'b1, 32'h0);
    issue(OP_SB,  32'h33,  32'h55,       32'h0,        0, 1, 0, 5'd10, 1'b1, 32'h0);
    issue(OP_LHU, 32'h42,  32'h0,        32'h1234F00D, 1, 0, 0, 5'd11, 1'b1, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      op = ops[$urandom_range(0, 8)];
      w  = $urandom_range(0, T + 1);
      fm = 0; fi = 0;
      if ($urandom_range(0, 9) == 0) fm = 1;
      else if (op_size(op) != 0 && w < T && $urandom_range(0, 6) == 0) begin
        fm = 2; fi = $urandom_range(0, w);
      end
      issue(op, $urandom, $urandom, $urandom, w, fm, fi, 5'($urandom), 1'($urandom), $urandom);
    end

    // Reset while BUSY drops the request at that edge
    bus_q.push_back('{addr: 32'h40, sel: 4'b1111, we: 1'b0, wdata: 32'h0});
    ack_wait = 1000;
    aluop_i = OP_LW; mem_addr_i = 32'h40;
    for (int c = 0; c < 8 && !dbus_req_o; c++) @(negedge clk);
    chk("rstbusy_req_seen", {31'd0, dbus_req_o}, 32'd1);
    #1 rst = 1'b1; aluop_i = OP_ALU;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstbusy_req", {31'd0, dbus_req_o}, 32'd0);
    chk("rstbusy_stall", {31'd0, stallreq_o}, 32'd0);
    chk("rstbusy_buserr", {31'd0, excp_buserr_o}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rstbusy_req_stays", {31'd0, dbus_req_o}, 32'd0);

    chk("wb_q_empty", wb_q.size(), 32'd0);
    chk("bus_q_empty", bus_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_lsu
`default_nettype wire

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
MEM-stage load/store unit. Sits between ex_mem and mem_wb and drives the data-bus master port.
- Non-memory instructions: rw/wreg/wdata pass straight through combinationally.
- Loads/stores: runs a single-outstanding request/ack bus transaction, stalls the pipeline via stallreq_o, then forwards load data (byte/half extracted, sign/zero-extended) to mem_wb.
- Includes alignment checking and an ack timeout.

Parameters:
ACK_TIMEOUT, 255, cycles in BUSY without dbus_ack_i before abort with bus error; 0 disables the timeout.
CNT_W, 8, width of timeout counter; must hold ACK_TIMEOUT.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rw_i  in  5  destination register from ex_mem
wreg_i  in  1  register write enable from ex_mem
wdata_i  in  32  ALU result from ex_mem
aluop_i  in  8  operation code; LB/LBU/LH/LHU/LW/SB/SH/SW select memory ops
mem_addr_i  in  32  effective byte address
reg2_i  in  32  store data (rt)
flush_i  in  1  pipeline flush from ctrl
rw_o  out  5  to mem_wb
wreg_o  out  1  to mem_wb
wdata_o  out  32  to mem_wb
stallreq_o  out  1  stall request to ctrl
excp_misalign_o  out  1  misaligned access, valid while op present
excp_buserr_o  out  1  1-cycle pulse on ack timeout
dbus_req_o  out  1  bus request (registered)
dbus_we_o  out  1  1=write
dbus_addr_o  out  32  word address; bits [1:0] forced 0
dbus_sel_o  out  4  byte lanes, big-endian
dbus_wdata_o  out  32  store data replicated to lanes
dbus_rdata_i  in  32  read data, valid with ack
dbus_ack_i  in  1  transfer complete

Behaviour:
- Reset:
  - state=IDLE; dbus_req_o=0, dbus_we_o=0, dbus_addr_o=0, dbus_sel_o=0, dbus_wdata_o=0.
  - timeout count=0; drop flag=0; captured data=0.
  - excp_buserr_o=0.
  - Combinational outputs follow inputs with state IDLE.
  - Reset while BUSY drops dbus_req_o at that edge with no writeback.
- FSM states: IDLE, BUSY, DONE.
- Non-memory op:
  - rw_o=rw_i, wreg_o=wreg_i, wdata_o=wdata_i.
  - stallreq_o=0; state stays IDLE.
- Alignment:
  - Half needs addr[0]=0; word needs addr[1:0]=00.
  - Misaligned op: no bus cycle; excp_misalign_o=1; wreg_o=0; stallreq_o=0.
- IDLE, aligned mem op, flush_i=0:
  - Register addr/sel/we/wdata; set dbus_req_o=1; go to BUSY.
  - stallreq_o=1.
- BUSY:
  - dbus_req_o and all bus outputs held stable; stallreq_o=1; counter increments.
  - On dbus_ack_i: capture rdata, clear dbus_req_o; go to DONE, or to IDLE if the drop flag is set.
  - On counter==ACK_TIMEOUT-1 without ack: clear dbus_req_o; pulse excp_buserr_o; go to IDLE; no writeback.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - stallreq_o=0.
  - wdata_o=extracted load data; wreg_o=wreg_i for loads, 0 for stores.
  - Next edge returns to IDLE.
- Latency: ack in first BUSY cycle gives 2 stall cycles; each extra wait cycle adds 1.
- Lane mapping (big-endian):
  - addr[1:0]=00 → sel 1000, data[31:24].
  - 01 → 0100, [23:16].
  - 10 → 0010, [15:8].
  - 11 → 0001, [7:0].
  - Half at 00 → 1100, [31:16]; half at 10 → 0011, [15:0].
  - Word → 1111.
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- Store data: SB replicates byte x4; SH replicates half x2; SW unchanged.
- flush_i:
  - In IDLE or DONE: no request, wreg_o=0, state→IDLE.
  - In BUSY: bus cycle is never abandoned. Set drop flag, keep req until ack or timeout, discard result; stallreq_o stays 1 until leaving BUSY.
- ex_mem inputs are guaranteed stable while stallreq_o=1.

Decomposition:
- Shared defines: aluop codes for the 8 memory ops, Enable/Disable, ZeroWord, RegBus/RegAddrBus widths, state encodings.
- One sub-module: lsu_align. Combinational block doing sel generation, store replication, load extract/extend and misalign detection; FSM stays in mem_lsu.

Test Plan:
- ALU op rw_i=3, wreg_i=1, wdata_i=0x1234 → same on outputs same cycle; stallreq_o=0; dbus_req_o never 1.
- LB addr 0x101, ack on first BUSY cycle, rdata=0x11F23344:
  - dbus_sel_o=0100, dbus_addr_o=0x100.
  - Exactly 2 stall cycles.
  - DONE wdata_o=0xFFFFFFF2; LBU → 0x000000F2.
- SH addr 0x202, reg2_i=0xAAAABEEF, ack after 3 wait cycles → sel=0011, dbus_wdata_o=0xBEEFBEEF, dbus_we_o=1, 5 stall cycles, wreg_o=0.
- LW addr 0x6 → excp_misalign_o=1, wreg_o=0, no dbus_req_o, stallreq_o=0.
- ACK_TIMEOUT=4, no ack → req drops after 4 BUSY cycles, excp_buserr_o 1-cycle pulse, state IDLE, no writeback.
- flush_i in 2nd BUSY cycle, ack 2 cycles later → req held until ack, no DONE, wreg_o never 1. Also assert rst in BUSY → req 0 at next edge.
